// File: rtl/sipo_framer_if.sv
// Bundle of serial-input and parallel-output signals for sipo_framer.
// The master is the serial source and word consumer; the slave is the framer itself.
interface sipo_framer_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output sin, sin_valid, pout_ready,
        input  pout, pout_valid, busy, overrun, parity_err
    );

    modport slave (
        input  sin, sin_valid, pout_ready,
        output pout, pout_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_framer.sv
// Serial-in parallel-out framer: shifts qualified bits into WIDTH-bit words and holds
// each word for a valid/ready consumer. Define SIPO_PARITY_EN for a trailing even-parity bit.
module sipo_framer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst,
    sipo_framer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {DATA, PARITY} state_t;

    state_t           state, stateNext;
    logic [CW-1:0]    cnt, cntNext;
    logic [WIDTH-1:0] shreg, shregNext, shifted, word;
    logic [WIDTH-1:0] poutReg, poutNext;
    logic             pvReg, pvNext;
    logic             ovReg, ovNext;
    logic             perrReg, perrNext;
    logic             complete, wordPerr;

    always_comb begin
        shifted = MSB_FIRST ? {shreg[WIDTH-2:0], bus.sin} : {bus.sin, shreg[WIDTH-1:1]};
    end

    // Framing: a word completes on the last data bit, or on the parity bit when enabled.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        shregNext = shreg;
        complete  = 1'b0;
        word      = shreg;
        wordPerr  = 1'b0;
        if (bus.sin_valid) begin
            case (state)
                DATA: begin
                    shregNext = shifted;
                    if (cnt == LAST) begin
                        cntNext = '0;
`ifdef SIPO_PARITY_EN
                        stateNext = PARITY;
`else
                        complete = 1'b1;
                        word     = shifted;
`endif
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    stateNext = DATA;
                    complete  = 1'b1;
                    word      = shreg;
                    wordPerr  = (^shreg) ^ bus.sin;
                end
`endif
                default: stateNext = DATA;
            endcase
        end
    end

    // A completed word is dropped, never stalled, when the previous one is still unread.
    always_comb begin
        poutNext = poutReg;
        pvNext   = pvReg;
        ovNext   = ovReg;
        perrNext = perrReg;
        if (complete) begin
            if (!pvReg || bus.pout_ready) begin
                poutNext = word;
                pvNext   = 1'b1;
                perrNext = wordPerr;
            end else begin
                ovNext = 1'b1;
            end
        end else if (pvReg && bus.pout_ready) begin
            pvNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= DATA;
            cnt     <= '0;
            shreg   <= '0;
            poutReg <= '0;
            pvReg   <= 1'b0;
            ovReg   <= 1'b0;
            perrReg <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            shreg   <= shregNext;
            poutReg <= poutNext;
            pvReg   <= pvNext;
            ovReg   <= ovNext;
            perrReg <= perrNext;
        end
    end

    assign bus.pout       = poutReg;
    assign bus.pout_valid = pvReg;
    assign bus.overrun    = ovReg;
    assign bus.parity_err = perrReg;
    assign bus.busy       = (cnt != '0) || (state == PARITY);
endmodule

// File: doc/sipo_framer.md
# sipo_framer

Parametrised serial-in parallel-out deserialiser, the next generation of the fixed 4-bit SIPO register. Shifts one bit per qualified clock, counts bits to frame a WIDTH-bit word, and presents the word in a holding register with a valid/ready handshake and overrun detection. It sits between a serial bit source (UART/SPI-style front end) and any parallel word consumer.

## Interface
- WIDTH, 8, data bits per word (≥2)
- MSB_FIRST, 1, 1: first received bit lands in pout[WIDTH-1]; 0: first bit lands in pout[0]
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled only on edges where this is 1
- pout  out  WIDTH  last completed word (holding register)
- pout_valid  out  1  pout holds an unconsumed word
- pout_ready  in  1  consumer accepts pout on an edge where pout_valid=1
- busy  out  1  partial word in progress (bit counter ≠ 0 or in PARITY state)
- overrun  out  1  sticky: a completed word was dropped
- parity_err  out  1  parity status of the word in pout (0 when SIPO_PARITY_EN undefined)

## Operation
- Reset (rst=0 at an edge): shift register, bit counter, pout, pout_valid, overrun, parity_err, busy all 0; state DATA. Overrides every other event on that edge, including a mid-word bit.
- sin_valid=0: shift register, counter and state hold; no bit consumed.
- MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}. MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
- Bit counter runs 0..WIDTH-1; increments per accepted data bit, wraps to 0 on the WIDTH-th bit.
- States: DATA (collect bits); PARITY (only with SIPO_PARITY_EN, collect one parity bit). DATA→PARITY on the WIDTH-th bit when enabled; PARITY→DATA on the accepted parity bit. Without the macro, state is always DATA.
- Word completion = edge accepting the final bit (WIDTH-th data bit, or parity bit when enabled). Completed word = shreg including the final data bit.
- On completion:
  - pout_valid=0, or pout_valid=1 and pout_ready=1 on the same edge: pout loads the new word, pout_valid=1.
  - pout_valid=1 and pout_ready=0: new word dropped, pout unchanged, overrun <= 1.
- No completion, pout_valid=1, pout_ready=1: pout_valid <= 0, pout holds its value.
- overrun clears only on reset.
- Receiving continues unconditionally; back-pressure never stalls the shift path.

## Timing
- Latency: word visible with pout_valid=1 one edge after the final bit is presented, i.e. in the cycle following the edge that samples it.
- Back-to-back words with sin_valid held 1 complete every WIDTH cycles (WIDTH+1 with parity); a consumer with pout_ready tied 1 never causes overrun.
- busy rises after the first accepted bit of a word and falls on the completion edge.
- pout_valid/pout/parity_err change only on rising clk edges; all outputs registered.

## Configuration
- Macro SIPO_PARITY_EN.
- Defined: one even-parity bit follows each WIDTH data bits. parity_err loads with pout = (^data) ^ parity_bit; a word with parity_err=1 is still delivered. Parity bit is not stored in pout.
- Undefined: no PARITY state, frames are WIDTH bits, parity_err constant 0.

## Test plan
- WIDTH=4, MSB_FIRST=1, rst low 2 cycles then high, sin_valid=1, sin 1,0,1,0 -> pout=4'b1010, pout_valid=1 the cycle after the 4th bit, busy=0 then.
- WIDTH=4, MSB_FIRST=0, same bits -> pout=4'b0101.
- pout_ready=0, send 1010 then 0110 -> pout stays 1010, overrun=1; raise pout_ready -> pout_valid drops next edge, overrun stays 1.
- pout_ready=1 pulsed on the exact edge a second word 0011 completes -> pout=0011, pout_valid stays 1, overrun=0.
- Send 2 bits then rst=0 for one edge then 1111 -> counter restarted, pout=1111, busy=0 and pout=0 during reset.
- SIPO_PARITY_EN, WIDTH=4: data 1011 parity 1 -> parity_err=0; data 1011 parity 0 -> pout=1011, parity_err=1; sin_valid gaps mid-frame leave result unchanged.
